kernel_param_streamer: RTL and testbench

// - Consumer end of the kernel-parameter loader. Captures the packed kernel vector when the loader's done rises.
// - Serialises it one weight per valid/ready beat to the conv MAC datapath.
// - Replays the kernel PASSES times per start. Element order is generation order: MS slot first, LS slot last.
// - Sits between the kernel loader and the conv-layer MAC array.

---
 rtl/kernel_pkg.sv | 26 ++
 rtl/kernel_param_streamer_if.sv | 35 +++
 rtl/kernel_param_streamer.sv | 167 ++++++++++++++++
 tb/tb_kernel_param_streamer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package  : kernel_pkg
// Purpose  : Shared definitions for the kernel-parameter path: default
//            element width/count, the streamer FSM encoding, and the
//            numeric "one" constants used by loader and bench to agree
//            on unit-valued kernels.
// Ports    : none (package)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package kernel_pkg;

  localparam int KER_WIDTH = 8;
  localparam int KER_SIZE  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READY  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  localparam logic [31:0] FP_ONE  = 32'h3f800000;
  localparam logic [31:0] INT_ONE = 32'd1;

endpackage
`default_nettype wire

// File: rtl/kernel_param_streamer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Interface : kernel_param_streamer_if
// Purpose   : Weight stream from the kernel streamer to the MAC array.
// Signals   : w_data  - current weight
//             w_valid - w_data valid
//             w_ready - MAC accepts the weight
//             w_last  - last element of a pass
//             w_idx   - element index within the pass (0 = first emitted)
// Modports  : master (streamer side), slave (MAC side)
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
interface kernel_param_streamer_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 2
) ();

  logic [WIDTH-1:0] w_data;
  logic             w_valid;
  logic             w_ready;
  logic             w_last;
  logic [IDX_W-1:0] w_idx;

  modport master (
    output w_data, w_valid, w_last, w_idx,
    input  w_ready
  );

  modport slave (
    input  w_data, w_valid, w_last, w_idx,
    output w_ready
  );

endinterface
`default_nettype wire

// File: rtl/kernel_param_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : kernel_param_streamer
// Purpose  : Consumer end of the kernel-parameter loader. Captures the packed
//            kernel on the rising edge of the loader's done level, then on
//            each start replays it PASSES times to the conv MAC datapath,
//            one weight per valid/ready beat, MS slot first.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            ker_map       - packed kernel, element k = ker_map[WIDTH*k +: WIDTH]
//            ker_done      - loader done level (rising edge = vector valid)
//            start         - 1-cycle pulse, stream the held kernel
//            flush         - drop held kernel, abort any stream
//            w             - weight stream (master modport)
//            loaded        - kernel held in shadow register
//            stream_done   - 1-cycle pulse after final beat of final pass
//            overrun       - sticky, ker_done rose while streaming
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module kernel_param_streamer
  import kernel_pkg::*;
#(
  parameter int WIDTH  = KER_WIDTH,
  parameter int SIZE   = KER_SIZE,
  parameter int PASSES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*SIZE-1:0]   ker_map,
  input  logic                    ker_done,
  input  logic                    start,
  input  logic                    flush,
  kernel_param_streamer_if.master w,
  output logic                    loaded,
  output logic                    stream_done,
  output logic                    overrun
);

  localparam int IDX_W  = (SIZE > 1)         ? $clog2(SIZE)         : 1;
  localparam int PASS_W = (PASSES > 1)       ? $clog2(PASSES)       : 1;
  localparam int SEL_W  = (WIDTH * SIZE > 1) ? $clog2(WIDTH * SIZE) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SIZE - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [PASS_W-1:0]       pass, pass_n;
  logic [WIDTH*SIZE-1:0]   shadow, shadow_n;
  logic                    loaded_n;
  logic                    overrun_n;
  logic                    stream_done_n;
  logic                    done_d;
  logic                    done_rise;
  logic                    valid;

  logic [IDX_W-1:0]        elem;
  logic [SEL_W-1:0]        base;
  logic [WIDTH-1:0]        elem_data;

  assign done_rise = ker_done & ~done_d;

  // Emission order is MS slot first, so beat idx maps to element SIZE-1-idx.
  assign elem      = IDX_LAST - idx;
  assign base      = SEL_W'(elem) * SEL_W'(WIDTH);
  assign elem_data = shadow[base +: WIDTH];

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      pass        <= '0;
      shadow      <= '0;
      loaded      <= 1'b0;
      overrun     <= 1'b0;
      stream_done <= 1'b0;
      done_d      <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      pass        <= pass_n;
      shadow      <= shadow_n;
      loaded      <= loaded_n;
      overrun     <= overrun_n;
      stream_done <= stream_done_n;
      done_d      <= ker_done;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    pass_n        = pass;
    shadow_n      = shadow;
    loaded_n      = loaded;
    overrun_n     = overrun;
    stream_done_n = 1'b0;
    valid         = (state == ST_STREAM);

    if (flush) begin
      state_n   = ST_IDLE;
      idx_n     = '0;
      pass_n    = '0;
      shadow_n  = '0;
      loaded_n  = 1'b0;
      overrun_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (done_rise) begin
            shadow_n = ker_map;
            loaded_n = 1'b1;
            state_n  = ST_READY;
          end
        end

        ST_READY: begin
          // A fresh kernel wins over a coincident start.
          if (done_rise) begin
            shadow_n = ker_map;
          end else if (start) begin
            idx_n   = '0;
            pass_n  = '0;
            state_n = ST_STREAM;
          end
        end

        ST_STREAM: begin
          // The shadow is frozen while streaming; a new kernel is only flagged.
          if (done_rise) begin
            overrun_n = 1'b1;
          end
          if (w.w_ready) begin
            if (idx == IDX_LAST) begin
              idx_n = '0;
              if (pass == PASS_LAST) begin
                pass_n        = '0;
                state_n       = ST_READY;
                stream_done_n = 1'b1;
              end else begin
                pass_n = pass + 1'b1;
              end
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end

        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign w.w_valid = valid;
  assign w.w_data  = valid ? elem_data : '0;
  assign w.w_last  = valid & (idx == IDX_LAST);
  assign w.w_idx   = idx;

endmodule
`default_nettype wire

// File: tb/tb_kernel_param_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_kernel_param_streamer
// Purpose  : Self-checking bench. Three streamers share one stimulus:
//            dut_a (8-bit, 3 elements, 1 pass), dut_b (8-bit, 3 elements,
//            2 passes) and dut_c (32-bit, 3 elements, 1 pass). A beat-level
//            reference model predicts every output each cycle; directed
//            steps add checks against fixed expected values.
// Ports    : none
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_kernel_param_streamer;
  import kernel_pkg::*;

  localparam int SIZE  = 3;
  localparam int IDX_W = 2;
  localparam int ND    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ker_done;
  logic        start;
  logic        flush;
  logic        w_ready;
  logic [23:0] map8;
  logic [95:0] map32;

  logic loaded_a, loaded_b, loaded_c;
  logic sd_a, sd_b, sd_c;
  logic ovr_a, ovr_b, ovr_c;

  kernel_param_streamer_if #(.WIDTH(8),  .IDX_W(IDX_W)) bus_a ();
  kernel_param_streamer_if #(.WIDTH(8),  .IDX_W(IDX_W)) bus_b ();
  kernel_param_streamer_if #(.WIDTH(32), .IDX_W(IDX_W)) bus_c ();

  assign bus_a.w_ready = w_ready;
  assign bus_b.w_ready = w_ready;
  assign bus_c.w_ready = w_ready;

  kernel_param_streamer #(.WIDTH(8), .SIZE(SIZE), .PASSES(1)) dut_a (
    .clk(clk), .rst(rst), .ker_map(map8), .ker_done(ker_done), .start(start),
    .flush(flush), .w(bus_a), .loaded(loaded_a), .stream_done(sd_a), .overrun(ovr_a)
  );

  kernel_param_streamer #(.WIDTH(8), .SIZE(SIZE), .PASSES(2)) dut_b (
    .clk(clk), .rst(rst), .ker_map(map8), .ker_done(ker_done), .start(start),
    .flush(flush), .w(bus_b), .loaded(loaded_b), .stream_done(sd_b), .overrun(ovr_b)
  );

  kernel_param_streamer #(.WIDTH(32), .SIZE(SIZE), .PASSES(1)) dut_c (
    .clk(clk), .rst(rst), .ker_map(map32), .ker_done(ker_done), .start(start),
    .flush(flush), .w(bus_c), .loaded(loaded_c), .stream_done(sd_c), .overrun(ovr_c)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: held kernel, flags, and the number of beats already
  // accepted in the current stream (stream length = PASSES * SIZE).
  logic [95:0] m_held   [ND];
  bit          m_loaded [ND];
  bit          m_ovr    [ND];
  bit          m_sd     [ND];
  bit          m_stream [ND];
  int          m_beat   [ND];
  bit          m_done_prev;

  logic [7:0]  seq_b [6];

  function automatic int wid(input int d);
    return (d == 2) ? 32 : 8;
  endfunction

  function automatic int passes(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] elem_of(input logic [95:0] k, input int d, input int e);
    logic [95:0] s;
    s = k >> (wid(d) * e);
    return (d == 2) ? s[31:0] : {24'b0, s[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe(input int d, output logic [31:0] data, output logic [31:0] idx,
                         output logic v, output logic l, output logic ld,
                         output logic ov, output logic sd);
    case (d)
      0: begin
        data = {24'b0, bus_a.w_data}; idx = 32'(bus_a.w_idx);
        v = bus_a.w_valid; l = bus_a.w_last; ld = loaded_a; ov = ovr_a; sd = sd_a;
      end
      1: begin
        data = {24'b0, bus_b.w_data}; idx = 32'(bus_b.w_idx);
        v = bus_b.w_valid; l = bus_b.w_last; ld = loaded_b; ov = ovr_b; sd = sd_b;
      end
      default: begin
        data = bus_c.w_data; idx = 32'(bus_c.w_idx);
        v = bus_c.w_valid; l = bus_c.w_last; ld = loaded_c; ov = ovr_c; sd = sd_c;
      end
    endcase
  endtask

  task automatic check_all();
    logic [31:0] data, idx;
    logic v, l, ld, ov, sd;
    for (int d = 0; d < ND; d++) begin
      observe(d, data, idx, v, l, ld, ov, sd);
      chk($sformatf("dut%0d w_valid", d), 96'(v), 96'(m_stream[d]));
      if (m_stream[d]) begin
        int pos;
        pos = m_beat[d] % SIZE;
        chk($sformatf("dut%0d w_data", d), 96'(data), 96'(elem_of(m_held[d], d, SIZE - 1 - pos)));
        chk($sformatf("dut%0d w_idx", d), 96'(idx), 96'(pos));
        chk($sformatf("dut%0d w_last", d), 96'(l), 96'(pos == SIZE - 1));
      end else begin
        chk($sformatf("dut%0d idle w_idx", d), 96'(idx), 96'(0));
        chk($sformatf("dut%0d idle w_last", d), 96'(l), 96'(0));
        if (!m_loaded[d]) chk($sformatf("dut%0d empty w_data", d), 96'(data), 96'(0));
      end
      chk($sformatf("dut%0d loaded", d), 96'(ld), 96'(m_loaded[d]));
      chk($sformatf("dut%0d overrun", d), 96'(ov), 96'(m_ovr[d]));
      chk($sformatf("dut%0d stream_done", d), 96'(sd), 96'(m_sd[d]));
    end
  endtask

  // Advance one clock with the currently driven inputs, then check.
  task automatic tick();
    bit rise;
    logic [95:0] m;
    rise = ker_done && !m_done_prev;
    for (int d = 0; d < ND; d++) begin
      m = (d == 2) ? map32 : {72'b0, map8};
      m_sd[d] = 1'b0;
      if (rst || flush) begin
        m_held[d] = '0; m_loaded[d] = 1'b0; m_ovr[d] = 1'b0;
        m_stream[d] = 1'b0; m_beat[d] = 0;
      end else if (m_stream[d]) begin
        if (rise) m_ovr[d] = 1'b1;
        if (w_ready) begin
          m_beat[d]++;
          if (m_beat[d] == passes(d) * SIZE) begin
            m_stream[d] = 1'b0;
            m_sd[d]     = 1'b1;
          end
        end
      end else if (m_loaded[d]) begin
        if (rise) m_held[d] = m;
        else if (start) begin
          m_stream[d] = 1'b1;
          m_beat[d]   = 0;
        end
      end else if (rise) begin
        m_held[d]   = m;
        m_loaded[d] = 1'b1;
      end
    end
    m_done_prev = rst ? 1'b0 : ker_done;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    start = 1'b0; flush = 1'b0; w_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    int sd_count;
    seq_b = '{8'hAA, 8'hBB, 8'hCC, 8'hAA, 8'hBB, 8'hCC};
    rst = 1'b1; ker_done = 1'b0; start = 1'b0; flush = 1'b0; w_ready = 1'b0;
    map8 = '0; map32 = '0; m_done_prev = 1'b0;

    // Reset: everything quiet and zero.
    tick(); tick();
    chk("reset a w_valid", 96'(bus_a.w_valid), 96'(0));
    chk("reset c w_data", 96'(bus_c.w_data), 96'(0));
    chk("reset a loaded", 96'(loaded_a), 96'(0));
    rst = 1'b0;

    // Basic stream (dut_c carries three unit floats at the same time).
    map8 = 24'h010203; map32 = {FP_ONE, FP_ONE, FP_ONE};
    ker_done = 1'b1; w_ready = 1'b1; tick();
    chk("t1 loaded", 96'(loaded_a), 96'(1));
    start = 1'b1; tick(); start = 1'b0;
    chk("t1 beat0", 96'(bus_a.w_data), 96'(8'h01));
    chk("t6 beat0", 96'(bus_c.w_data), 96'(FP_ONE));
    tick();
    chk("t1 beat1", 96'(bus_a.w_data), 96'(8'h02));
    chk("t1 idx1", 96'(bus_a.w_idx), 96'(1));
    tick();
    chk("t1 beat2", 96'(bus_a.w_data), 96'(8'h03));
    chk("t1 last", 96'(bus_a.w_last), 96'(1));
    chk("t6 beat2", 96'(bus_c.w_data), 96'(FP_ONE));
    tick();
    chk("t1 stream_done", 96'(sd_a), 96'(1));
    chk("t1 loaded after", 96'(loaded_a), 96'(1));
    idle(4);

    // Backpressure: ready 1,0,0,1,1 holds the middle weight.
    start = 1'b1; tick(); start = 1'b0;
    chk("t2 beat0", 96'(bus_a.w_data), 96'(8'h01));
    w_ready = 1'b1; tick(); chk("t2 hold0", 96'(bus_a.w_data), 96'(8'h02));
    w_ready = 1'b0; tick(); chk("t2 hold1", 96'(bus_a.w_data), 96'(8'h02));
    tick();                 chk("t2 hold2", 96'(bus_a.w_data), 96'(8'h02));
    chk("t2 hold valid", 96'(bus_a.w_valid), 96'(1));
    w_ready = 1'b1; tick(); chk("t2 beat2", 96'(bus_a.w_data), 96'(8'h03));
    tick();                 chk("t2 stream_done", 96'(sd_a), 96'(1));
    idle(8);

    // Two passes on dut_b: six back-to-back beats, one stream_done.
    map8 = 24'hAABBCC; ker_done = 1'b0; tick();
    ker_done = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    sd_count = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3 beat%0d", i), 96'(bus_b.w_data), 96'(seq_b[i]));
      chk($sformatf("t3 last%0d", i), 96'(bus_b.w_last), 96'((i % 3) == 2));
      sd_count += int'(sd_b);
      tick();
    end
    sd_count += int'(sd_b);
    chk("t3 stream_done count", 96'(sd_count), 96'(1));
    idle(4);

    // start ignored in IDLE; kernel arriving mid-stream only sets overrun.
    flush = 1'b1; tick(); flush = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t4 no stream from idle", 96'(bus_a.w_valid), 96'(0));
    map8 = 24'h112233; ker_done = 1'b0; tick();
    ker_done = 1'b1; tick();
    start = 1'b1; w_ready = 1'b0; tick(); start = 1'b0;
    chk("t4 beat0", 96'(bus_a.w_data), 96'(8'h11));
    ker_done = 1'b0; tick();
    map8 = 24'hFFFFFF; ker_done = 1'b1; w_ready = 1'b1; tick();
    chk("t4 old kernel", 96'(bus_a.w_data), 96'(8'h22));
    chk("t4 overrun", 96'(ovr_a), 96'(1));

    // Flush after the first beat, then reset mid-stream.
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t5 flush valid", 96'(bus_a.w_valid), 96'(0));
    chk("t5 flush loaded", 96'(loaded_a), 96'(0));
    chk("t5 flush overrun", 96'(ovr_a), 96'(0));
    map8 = 24'h445566; ker_done = 1'b0; tick();
    ker_done = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5 rst valid", 96'(bus_b.w_valid), 96'(0));
    chk("t5 rst data", 96'(bus_b.w_data), 96'(0));
    chk("t5 rst loaded", 96'(loaded_b), 96'(0));
    chk("t5 rst stream_done", 96'(sd_b), 96'(0));

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      flush   = ($urandom_range(0, 79) == 0);
      start   = ($urandom_range(0, 3) == 0);
      w_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 5) == 0) ker_done = ~ker_done;
      if ($urandom_range(0, 3) == 0) begin
        map8  = 24'($urandom());
        map32 = {$urandom(), $urandom(), $urandom()};
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
